// File: rtl/rgb_pkg.sv
// Shared types and defaults for the RGB fade block.
// Channel state encoding and the prescaler width helper.
package rgb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } chan_state_e;

    localparam int PWM_BITS_DEF = 8;
    localparam int FADE_DIV_DEF = 24_000;
    localparam int STEP_DEF     = 1;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_fade_if.sv
// Colour request and LED drive bundle for rgb_fade.
// The sequencer side is master, the fade block is slave.
interface rgb_fade_if;

    logic [2:0] i_rgb;
    logic       o_ledr;
    logic       o_ledg;
    logic       o_ledb;
    logic       o_busy;

    modport master (
        output i_rgb,
        input  o_ledr,
        input  o_ledg,
        input  o_ledb,
        input  o_busy
    );

    modport slave (
        input  i_rgb,
        output o_ledr,
        output o_ledg,
        output o_ledb,
        output o_busy
    );

endinterface

// File: rtl/rgb_pwm_chan.sv
// One LED channel: duty register, fade FSM, PWM compare
// and registered pin drive.
module rgb_pwm_chan
    import rgb_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int STEP       = STEP_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_tgt,
    input  logic                i_upd,
    input  logic [PWM_BITS-1:0] i_cnt,
    output logic                o_led,
    output logic                o_busy
);

    localparam int W = PWM_BITS + 1;
    localparam logic [W-1:0] MAX_X  = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [W-1:0] STEP_X = W'(STEP);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    chan_state_e         st_q, st_d;
    logic                led_q, led_d;
    logic [W-1:0]        duty_x, tgt_x, up_x, dn_x;

    // Step the duty toward the target, clamping at the target.
    always_comb begin
        duty_x = {1'b0, duty_q};
        tgt_x  = i_tgt ? MAX_X : '0;
        up_x   = duty_x + STEP_X;
        dn_x   = duty_x - STEP_X;
        duty_d = duty_q;
        st_d   = IDLE;
        unique case (1'b1)
            (duty_x < tgt_x): begin
                st_d = RISE;
                if (i_upd) begin
                    duty_d = (up_x > tgt_x) ?
                        tgt_x[PWM_BITS-1:0] :
                        up_x[PWM_BITS-1:0];
                end
            end
            (duty_x > tgt_x): begin
                st_d = FALL;
                if (i_upd) begin
                    duty_d = (dn_x[PWM_BITS] || dn_x < tgt_x) ?
                        tgt_x[PWM_BITS-1:0] :
                        dn_x[PWM_BITS-1:0];
                end
            end
            default: st_d = IDLE;
        endcase
        led_d = (duty_q == '1) ||
                ((duty_q != '0) && (duty_q > i_cnt));
    end

    // Channel state, duty and pin drive registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            duty_q <= '0;
            st_q   <= IDLE;
            led_q  <= ACTIVE_LOW;
        end else begin
            duty_q <= duty_d;
            st_q   <= st_d;
            led_q  <= led_d ^ ACTIVE_LOW;
        end
    end

    assign o_led  = led_q;
    assign o_busy = (st_q != IDLE);

endmodule

// File: rtl/rgb_fade.sv
// RGB LED fader: shared PWM counter and fade prescaler
// driving three independent fading channels.
module rgb_fade
    import rgb_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int FADE_DIV   = FADE_DIV_DEF,
    parameter int STEP       = STEP_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    rgb_fade_if.slave  bus
);

    localparam int PW = cnt_w(FADE_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(FADE_DIV - 1);

    logic [1:0]          rsync_q;
    logic                rst_n;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic                pend_q, pend_d;
    logic [2:0]          tgt_q;
    logic                wrap, upd;
    logic                busy_r, busy_g, busy_b;
    logic                led_r, led_g, led_b;

    // Assert reset at once, release it two edges later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsync_q <= '0;
        end else begin
            rsync_q <= {rsync_q[0], 1'b1};
        end
    end

    assign rst_n = rsync_q[1];

    always_comb begin
        wrap   = (pre_q == PRE_LAST);
        upd    = (cnt_q == '1) && pend_q;
        cnt_d  = cnt_q + PWM_BITS'(1);
        pre_d  = wrap ? '0 : pre_q + PW'(1);
        pend_d = wrap | (pend_q & ~upd);
    end

    // Shared PWM counter, fade prescaler and colour target.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            pend_q <= 1'b0;
            tgt_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            pend_q <= pend_d;
            tgt_q  <= bus.i_rgb;
        end
    end

    rgb_pwm_chan #(
        .PWM_BITS   (PWM_BITS),
        .STEP       (STEP),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_red (
        .i_clk   (i_clk),
        .i_rst_n (rst_n),
        .i_tgt   (tgt_q[2]),
        .i_upd   (upd),
        .i_cnt   (cnt_q),
        .o_led   (led_r),
        .o_busy  (busy_r)
    );

    rgb_pwm_chan #(
        .PWM_BITS   (PWM_BITS),
        .STEP       (STEP),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_grn (
        .i_clk   (i_clk),
        .i_rst_n (rst_n),
        .i_tgt   (tgt_q[1]),
        .i_upd   (upd),
        .i_cnt   (cnt_q),
        .o_led   (led_g),
        .o_busy  (busy_g)
    );

    rgb_pwm_chan #(
        .PWM_BITS   (PWM_BITS),
        .STEP       (STEP),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_blu (
        .i_clk   (i_clk),
        .i_rst_n (rst_n),
        .i_tgt   (tgt_q[0]),
        .i_upd   (upd),
        .i_cnt   (cnt_q),
        .o_led   (led_b),
        .o_busy  (busy_b)
    );

    assign bus.o_ledr = led_r;
    assign bus.o_ledg = led_g;
    assign bus.o_ledb = led_b;
    assign bus.o_busy = busy_r | busy_g | busy_b;

endmodule

// File: tb/tb_rgb_fade.sv
// Bench for rgb_fade: four parameter sets run side by side
// against a cycle model built from the fade rules.
module tb_rgb_fade;

    localparam int NI = 4;

    int pb [NI] = '{4, 4, 4, 3};
    int fd [NI] = '{1, 1, 16, 5};
    int stp[NI] = '{1, 4, 1, 3};
    bit al [NI] = '{1'b1, 1'b1, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rgb = 3'b000;

    int total = 0;
    int bad = 0;

    int cnt [NI];
    int pre [NI];
    int pend[NI];
    int duty[NI][3];
    int tgt [NI][3];
    bit led_e[NI][3];
    bit busy_e[NI];
    int rel;

    rgb_fade_if b0 ();
    rgb_fade_if b1 ();
    rgb_fade_if b2 ();
    rgb_fade_if b3 ();

    rgb_fade #(.PWM_BITS(4), .FADE_DIV(1), .STEP(1),
               .ACTIVE_LOW(1'b1))
    dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));

    rgb_fade #(.PWM_BITS(4), .FADE_DIV(1), .STEP(4),
               .ACTIVE_LOW(1'b1))
    dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));

    rgb_fade #(.PWM_BITS(4), .FADE_DIV(16), .STEP(1),
               .ACTIVE_LOW(1'b1))
    dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));

    rgb_fade #(.PWM_BITS(3), .FADE_DIV(5), .STEP(3),
               .ACTIVE_LOW(1'b0))
    dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(b3));

    always #5 clk = ~clk;

    task automatic set_rgb(input logic [2:0] v);
        rgb = v;
        b0.i_rgb = v;
        b1.i_rgb = v;
        b2.i_rgb = v;
        b3.i_rgb = v;
    endtask

    function automatic int mx(input int k);
        return (1 << pb[k]) - 1;
    endfunction

    task automatic model_reset();
        rel = 0;
        for (int k = 0; k < NI; k++) begin
            cnt[k] = 0;
            pre[k] = 0;
            pend[k] = 0;
            busy_e[k] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                duty[k][c] = 0;
                tgt[k][c] = 0;
                led_e[k][c] = al[k];
            end
        end
    endtask

    task automatic model_step();
        int m;
        bit up, wrap, b, on;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (rel < 2) begin
            rel++;
            return;
        end
        for (int k = 0; k < NI; k++) begin
            m = mx(k);
            up = (cnt[k] == m) && (pend[k] != 0);
            wrap = (pre[k] == fd[k] - 1);
            b = 1'b0;
            for (int c = 0; c < 3; c++) begin
                on = (duty[k][c] == m) || (duty[k][c] > cnt[k]);
                led_e[k][c] = on ^ al[k];
                if (duty[k][c] != tgt[k][c]) b = 1'b1;
                if (up) begin
                    if (duty[k][c] < tgt[k][c]) begin
                        duty[k][c] += stp[k];
                        if (duty[k][c] > tgt[k][c])
                            duty[k][c] = tgt[k][c];
                    end else if (duty[k][c] > tgt[k][c]) begin
                        duty[k][c] -= stp[k];
                        if (duty[k][c] < tgt[k][c])
                            duty[k][c] = tgt[k][c];
                    end
                end
                tgt[k][c] = rgb[2-c] ? m : 0;
            end
            busy_e[k] = b;
            cnt[k] = (cnt[k] + 1) % (m + 1);
            pre[k] = wrap ? 0 : pre[k] + 1;
            if (wrap) pend[k] = 1;
            else if (up) pend[k] = 0;
        end
    endtask

    function automatic int obs(input int k, input int c);
        logic [3:0] v;
        case (k)
            0: v = {b0.o_ledr, b0.o_ledg, b0.o_ledb, b0.o_busy};
            1: v = {b1.o_ledr, b1.o_ledg, b1.o_ledb, b1.o_busy};
            2: v = {b2.o_ledr, b2.o_ledg, b2.o_ledb, b2.o_busy};
            default: v = {b3.o_ledr, b3.o_ledg, b3.o_ledb, b3.o_busy};
        endcase
        return int'(v[3-c]);
    endfunction

    task automatic chk(input string tag, input int k, input int c,
                       input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s inst=%0d ch=%0d got=%0d want=%0d",
                   tag, k, c, o, e);
        end
    endtask

    task automatic to_fail(input string tag);
        total++;
        bad++;
        $error("FAIL %s timeout got=none want=event", tag);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < 3; c++)
                chk(tag, k, c, obs(k, c), int'(led_e[k][c]));
            chk({tag, "_busy"}, k, 3, obs(k, 3), int'(busy_e[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all("cyc");
    endtask

    // Wait for each red duty update of instance k and measure
    // the new duty as on-cycles over the following period.
    task automatic expect_duties(input int k, input int seq[4],
                                 input string tag);
        int prev, n, on;
        for (int i = 0; i < 4; i++) begin
            prev = duty[k][0];
            n = 0;
            while (duty[k][0] == prev && n < 40) begin
                tick();
                n++;
            end
            if (duty[k][0] == prev) begin
                to_fail(tag);
                return;
            end
            on = 0;
            repeat (15) begin
                tick();
                if (obs(k, 0) == (al[k] ? 0 : 1)) on++;
            end
            chk(tag, k, 0, on, seq[i]);
        end
    endtask

    task automatic wait_duty(input int k, input int v,
                             input string tag);
        int n;
        n = 0;
        while (duty[k][0] != v && n < 250) begin
            tick();
            n++;
        end
        if (duty[k][0] != v) to_fail(tag);
    endtask

    task automatic pulse_reset(input int dly, input int hold);
        #(dly);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async");
        repeat (hold) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        set_rgb(3'b000);
        model_reset();
        repeat (4) tick();
        rst_n = 1'b1;

        repeat (64) tick();

        set_rgb(3'b100);
        expect_duties(1, '{4, 8, 12, 15}, "up_step4");
        repeat (280) tick();

        set_rgb(3'b000);
        expect_duties(1, '{11, 7, 3, 0}, "dn_step4");
        repeat (280) tick();

        set_rgb(3'b100);
        wait_duty(0, 7, "reach7");
        set_rgb(3'b000);
        expect_duties(0, '{6, 5, 4, 3}, "reverse");

        set_rgb(3'b100);
        wait_duty(0, 9, "reach9");
        repeat (5) tick();
        pulse_reset(2, 3);
        expect_duties(0, '{1, 2, 3, 4}, "restart");

        for (int i = 0; i < 15; i++) begin
            set_rgb(3'($urandom_range(0, 7)));
            repeat ($urandom_range(3, 150)) tick();
            if (i == 7) pulse_reset($urandom_range(1, 3), 3);
        end
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_fade.md
RGB_FADE -- requirements
Module: rgb_fade

Interface
REQ-001 Parameter PWM_BITS, default 8, sets the width of the PWM counter and of each duty register.
REQ-002 Parameter FADE_DIV, default 24_000, sets the number of i_clk cycles per fade tick (range 1..2^20).
REQ-003 Parameter STEP, default 1, sets the duty change per applied fade tick (range 1..2^PWM_BITS-1).
REQ-004 Parameter ACTIVE_LOW, default 1, inverts all three LED outputs when set to 1.
REQ-005 i_clk  input  1  is the single clock; all state is clocked on its rising edge.
REQ-006 i_rst_n  input  1  is the reset: asynchronous assert, active-low.
REQ-007 i_rgb  input  3  is the requested colour {red, green, blue}; bit=1 means the channel is on; it arrives from the colour-sequencer counter stage.
REQ-008 o_ledr, o_ledg, o_ledb  output  1 each  are the registered PWM drives for the red, green and blue LEDs.
REQ-009 o_busy  output  1  is high while any channel duty differs from its target.

Function
REQ-010 The block SHALL register i_rgb into a 3-bit target register every cycle; target per channel = bit ? 2^PWM_BITS-1 (MAX) : 0.
REQ-011 The PWM counter SHALL increment every cycle and wrap from MAX to 0, giving a period of 2^PWM_BITS cycles.
REQ-012 The fade prescaler SHALL count 0..FADE_DIV-1, wrap to 0, and set a pending flag on the wrap cycle.
REQ-013 Duty registers SHALL update only on the cycle where the PWM counter equals MAX and pending is set; that cycle SHALL clear pending.
REQ-014 If the prescaler wrap and a pending consume occur in the same cycle, pending SHALL stay set (set wins).
REQ-015 Each duty register SHALL move toward its target by STEP per update, saturating exactly at the target with no overshoot.
REQ-016 Arithmetic SHALL use a PWM_BITS+1-bit intermediate so that neither increment nor decrement wraps.
REQ-017 A target change mid-fade SHALL reverse direction from the current duty at the next update, with no jump.
REQ-018 Raw channel on = (duty > pwm_cnt), except duty==MAX SHALL force constant on and duty==0 SHALL force constant off.
REQ-019 Raw channel state SHALL be registered, then XORed with ACTIVE_LOW; latency from duty/counter to pin is 1 cycle.
REQ-020 Each channel SHALL run a 3-state FSM: IDLE (duty==target), RISE (duty<target), FALL (duty>target), re-evaluated every cycle from registers.
REQ-021 o_busy SHALL be the OR of the three channels being in RISE or FALL, decoded from registers (glitch-free).

Reset
REQ-022 While i_rst_n is low, the following SHALL be 0: PWM counter, prescaler, pending, targets, and duties.
REQ-023 While i_rst_n is low, o_busy SHALL be 0 and every LED output SHALL be at its off level (1 if ACTIVE_LOW else 0).
REQ-024 Reset deassertion SHALL be synchronised through a 2-flop synchroniser; the first count occurs on the third rising edge after release.
REQ-025 Reset asserted mid-fade SHALL abandon the fade immediately, with no completion of the current step.

Structure
REQ-026 Package rgb_pkg SHALL hold the chan_state_e enum (IDLE, RISE, FALL) and the default constants for PWM_BITS, FADE_DIV and STEP.
REQ-027 Sub-module rgb_pwm_chan (duty register, FSM, compare, output flop) SHALL be instantiated three times; the counter and prescaler are shared at top level.

Verification
REQ-028 Scenario 1: PWM_BITS=4, FADE_DIV=1, STEP=1, i_rgb=000 after reset -> all LEDs constant 1 (ACTIVE_LOW) and o_busy=0 for 64 cycles.
REQ-029 Scenario 2: same parameters, i_rgb=100 -> o_busy rises 2 cycles later; red duty steps 0→15 once per 16-cycle period; o_busy falls after 15 updates; o_ledr is then constant 0.
REQ-030 Scenario 3: STEP=4, ramp up then down -> red duty sequence 0,4,8,12,15 then 15,11,7,3,0 (saturation checked).
REQ-031 Scenario 4: switch i_rgb 100→000 when duty=7 -> the next update gives duty=6, with no jump to 0 or 15.
REQ-032 Scenario 5: FADE_DIV=16, PWM_BITS=4 -> exactly one update per 16 cycles, including the cycle where prescaler wrap and consume coincide.
REQ-033 Scenario 6: assert i_rst_n low at duty=9 -> outputs go off asynchronously; after release the duty restarts from 0.
